// File: rtl/exdecompress_tbl_pkg.sv
// Shared codeword definitions and the single-word decoder for the exbus decompressor.
// The decoder is purely combinational; table lookups are resolved later in the pipeline.
package exdecompress_tbl_pkg;

  typedef enum logic [1:0] {
    CW_ADDR    = 2'b00,
    CW_WRITE   = 2'b01,
    CW_READ    = 2'b10,
    CW_SPECIAL = 2'b11
  } cw_type_e;

  localparam logic [4:0] SPC_FLUSH = 5'b11110;
  localparam logic [1:0] WR_LOOKUP = 2'b10;   // i[32:31] of a write word
  localparam logic [2:0] WR_SHORT  = 3'b110;  // i[32:30]
  localparam logic [2:0] WR_LONG   = 3'b111;  // i[32:30]

  typedef struct packed {
    logic [34:0] word;
    logic        store;
    logic        lookup;
    logic [8:0]  off;
    logic        flush;
  } dec_t;

  function automatic dec_t decode(input logic [34:0] cw);
    dec_t d;
    d = '0;
    unique case (cw_type_e'(cw[34:33]))
      CW_ADDR: begin
        if (!cw[32])      d.word = {3'b000, cw[31:2], 1'b0, cw[0]};
        else if (!cw[31]) d.word = {3'b001, {30{cw[30]}}, cw[30:29]};
        else if (!cw[30]) d.word = {2'b00, cw[29], {25{cw[28]}}, cw[28:22]};
        else              d.word = {2'b00, cw[29], {18{cw[28]}}, cw[28:15]};
      end
      CW_WRITE: begin
        d.word[34:32] = 3'b010;
        if (!cw[32]) begin
          d.word[31:0] = cw[31:0];
          d.store      = 1'b1;
        end else if (cw[32:31] == WR_LOOKUP) begin
          d.lookup = 1'b1;
          d.off    = cw[30] ? cw[29:21] : {7'h0, cw[29:28]};
        end else if (cw[32:30] == WR_SHORT) begin
          d.word[31:0] = {{24{cw[29]}}, cw[29:22]};
        end else begin
          d.word[31:0] = {{17{cw[29]}}, cw[29:15]};
          d.store      = 1'b1;
        end
      end
      CW_READ:
        d.word = {2'b10, 21'h0,
                  cw[32] ? 12'd17 + {1'b0, cw[31:21]} : 12'd1 + {8'h0, cw[31:28]}};
      CW_SPECIAL: begin
        d.word  = {2'b11, cw[32:28], 28'h0};
        d.flush = (cw[32:28] == SPC_FLUSH);
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exdecompress_tbl_if.sv
// Word stream bundle between link decoder (master) and decompressor (slave).
interface exdecompress_tbl_if;
  logic        i_stb;
  logic        o_busy;
  logic [34:0] i_word;
  logic        o_stb;
  logic        i_busy;
  logic [34:0] o_word;
  logic        o_err;

  modport master (output i_stb, i_word, i_busy, input o_busy, o_stb, o_word, o_err);
  modport slave  (input i_stb, i_word, i_busy, output o_busy, o_stb, o_word, o_err);
endinterface

// File: rtl/exdecompress_tbl_table.sv
// History table: 2^LGTABLE x 32 RAM with valid bitmap, registered read,
// same-cycle write-to-read bypass and synchronous flush of the valid bits.
module exdecomp_table #(
  parameter int unsigned LGTABLE = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_we,
  input  logic [LGTABLE-1:0] i_waddr,
  input  logic [31:0]        i_wdata,
  input  logic               i_re,
  input  logic [LGTABLE-1:0] i_raddr,
  output logic [31:0]        o_rdata,
  output logic               o_rvalid
);
  logic [31:0]             mem [0:(1<<LGTABLE)-1];
  logic [(1<<LGTABLE)-1:0] valid;

  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)     valid <= '0;
    else if (i_flush) valid <= '0;
    else if (i_we)    valid[i_waddr] <= 1'b1;

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else if (i_re) begin
      if (i_we && (i_waddr == i_raddr)) begin
        o_rdata  <= i_wdata;
        o_rvalid <= 1'b1;
      end else begin
        o_rdata  <= mem[i_raddr];
        o_rvalid <= valid[i_raddr];
      end
    end
endmodule

// File: rtl/exdecompress_tbl.sv
// exbus codeword decompressor with history table: 3-stage pipeline (decode/read, resolve, output).
// Optional EXDECOMPRESS_STATS_EN adds o_lookups/o_stale beat counters.
module exdecompress_tbl
  import exdecompress_tbl_pkg::*;
#(
  parameter int unsigned LGTABLE      = 10,
  parameter bit          OPT_LOWPOWER = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  exdecompress_tbl_if.slave  bus,
  output logic               o_active
`ifdef EXDECOMPRESS_STATS_EN
  ,
  output logic [31:0]        o_lookups,
  output logic [31:0]        o_stale
`endif
);
  dec_t               dec;
  logic               s1_ready, s2_ready, s3_ready, accept, flush_acc, tbl_we;
  logic               s1_vld, s1_store, s1_lookup;
  logic [34:0]        s1_word;
  logic [LGTABLE-1:0] s1_waddr, ptr, raddr;
  logic               s2_vld, s2_err;
  logic [34:0]        s2_word;
  logic [31:0]        rdata;
  logic               rvalid;

  always_comb begin
    dec       = decode(bus.i_word);
    s3_ready  = !bus.o_stb || !bus.i_busy;
    s2_ready  = !s2_vld || s3_ready;
    s1_ready  = !s1_vld || s2_ready;
    accept    = bus.i_stb && s1_ready;
    flush_acc = accept && dec.flush;
    // A store leaving s1 in the same cycle a flush is accepted must not survive the flush.
    tbl_we    = s1_vld && s1_store && s2_ready && !flush_acc;
    raddr     = ptr - LGTABLE'(1) - LGTABLE'(dec.off);
  end

  assign bus.o_busy = !s1_ready;
  assign o_active   = s1_vld || s2_vld;

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)                   ptr <= '0;
    else if (flush_acc)            ptr <= '0;
    else if (accept && dec.store)  ptr <= ptr + LGTABLE'(1);

  exdecomp_table #(.LGTABLE(LGTABLE)) u_table (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_flush  (flush_acc),
    .i_we     (tbl_we),
    .i_waddr  (s1_waddr),
    .i_wdata  (s1_word[31:0]),
    .i_re     (accept && dec.lookup),
    .i_raddr  (raddr),
    .o_rdata  (rdata),
    .o_rvalid (rvalid)
  );

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      s1_vld    <= 1'b0;
      s1_store  <= 1'b0;
      s1_lookup <= 1'b0;
      s1_waddr  <= '0;
      s1_word   <= '0;
    end else if (s1_ready) begin
      s1_vld    <= accept && !dec.flush;
      s1_store  <= accept && dec.store;
      s1_lookup <= accept && dec.lookup;
      s1_waddr  <= ptr;
      s1_word   <= (OPT_LOWPOWER && !(accept && !dec.flush)) ? '0 : dec.word;
    end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      s2_vld  <= 1'b0;
      s2_err  <= 1'b0;
      s2_word <= '0;
    end else if (s2_ready) begin
      s2_vld <= s1_vld;
      s2_err <= s1_vld && s1_lookup && !rvalid;
      if (OPT_LOWPOWER && !s1_vld) s2_word <= '0;
      else if (s1_lookup)          s2_word <= {3'b010, rvalid ? rdata : 32'h0};
      else                         s2_word <= s1_word;
    end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      bus.o_stb  <= 1'b0;
      bus.o_err  <= 1'b0;
      bus.o_word <= '0;
    end else if (s3_ready) begin
      bus.o_stb  <= s2_vld;
      bus.o_err  <= s2_vld && s2_err;
      bus.o_word <= (OPT_LOWPOWER && !s2_vld) ? '0 : s2_word;
    end

`ifdef EXDECOMPRESS_STATS_EN
  logic s2_lookup, o_lookup;

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      s2_lookup <= 1'b0;
      o_lookup  <= 1'b0;
      o_lookups <= '0;
      o_stale   <= '0;
    end else begin
      if (s2_ready) s2_lookup <= s1_vld && s1_lookup;
      if (s3_ready) o_lookup  <= s2_vld && s2_lookup;
      if (bus.o_stb && !bus.i_busy) begin
        if (o_lookup)  o_lookups <= o_lookups + 32'd1;
        if (bus.o_err) o_stale   <= o_stale + 32'd1;
      end
    end
`endif
endmodule

// File: tb/tb_exdecompress_tbl.sv
// Directed bench for exdecompress_tbl: sequential reference model (stored-word history queue)
// checked beat-by-beat, plus hand-computed literals on selected beats.
module tb_exdecompress_tbl;
  localparam int unsigned LG    = 10;
  localparam int          DEPTH = 1 << LG;

  logic clk = 1'b0;
  logic rst;
  logic o_active;
  exdecompress_tbl_if bus();
`ifdef EXDECOMPRESS_STATS_EN
  logic [31:0] o_lookups, o_stale;
`endif

  exdecompress_tbl #(.LGTABLE(LG), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .bus      (bus),
    .o_active (o_active)
`ifdef EXDECOMPRESS_STATS_EN
    ,
    .o_lookups(o_lookups),
    .o_stale  (o_stale)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] hist_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void store(input logic [31:0] v);
    hist_q.push_back(v);
    if (hist_q.size() > DEPTH) void'(hist_q.pop_front());
  endfunction

  // Reference: every accepted word, in order, yields its {err,word} (flush yields nothing).
  function automatic void model_push(input logic [34:0] w);
    logic signed [31:0] sv;
    int off, cnt;
    case (w[34:33])
      2'b00: begin
        if (!w[32]) exp_q.push_back({1'b0, 3'b000, w[31:2], 1'b0, w[0]});
        else if (!w[31]) begin sv = $signed(w[30:29]); exp_q.push_back({1'b0, 3'b001, sv}); end
        else if (!w[30]) begin sv = $signed(w[28:22]); exp_q.push_back({1'b0, 2'b00, w[29], sv}); end
        else begin sv = $signed(w[28:15]); exp_q.push_back({1'b0, 2'b00, w[29], sv}); end
      end
      2'b01: begin
        if (!w[32]) begin store(w[31:0]); exp_q.push_back({1'b0, 3'b010, w[31:0]}); end
        else if (!w[31]) begin
          off = w[30] ? int'(w[29:21]) : int'(w[29:28]);
          if (off < hist_q.size()) exp_q.push_back({1'b0, 3'b010, hist_q[hist_q.size()-1-off]});
          else                     exp_q.push_back({1'b1, 3'b010, 32'h0});
        end
        else if (!w[30]) begin sv = $signed(w[29:22]); exp_q.push_back({1'b0, 3'b010, sv}); end
        else begin sv = $signed(w[29:15]); store(sv); exp_q.push_back({1'b0, 3'b010, sv}); end
      end
      2'b10: begin
        cnt = w[32] ? 17 + int'(w[31:21]) : 1 + int'(w[31:28]);
        exp_q.push_back({1'b0, 2'b10, 21'h0, 12'(cnt)});
      end
      default: begin
        if (w[32:28] == 5'b11110) hist_q.delete();
        else exp_q.push_back({1'b0, 2'b11, w[32:28], 28'h0});
      end
    endcase
  endfunction

  function automatic logic [34:0] wr(input logic [31:0] v);    return {2'b01, 1'b0, v};              endfunction
  function automatic logic [34:0] lks(input logic [1:0] o);    return {2'b01, 3'b100, o, 28'h0};     endfunction
  function automatic logic [34:0] lkl(input logic [8:0] o);    return {2'b01, 3'b101, o, 21'h0};     endfunction
  function automatic logic [34:0] wr8(input logic [7:0] b);    return {2'b01, 3'b110, b, 22'h0};     endfunction
  function automatic logic [34:0] wr15(input logic [14:0] h);  return {2'b01, 3'b111, h, 15'h0};     endfunction
  function automatic logic [34:0] rdl(input logic [10:0] n);   return {2'b10, 1'b1, n, 21'h0};       endfunction
  function automatic logic [34:0] rds(input logic [3:0] n);    return {2'b10, 1'b0, n, 28'h0};       endfunction
  function automatic logic [34:0] spc(input logic [4:0] r);    return {2'b11, r, 28'h0};             endfunction

  // Compare process: one check per emitted beat, plus stability while stalled.
  initial begin : cmp
    logic        held_v;
    logic [35:0] held, got, e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.o_stb) held_v = 1'b0;
      else begin
        got = {bus.o_err, bus.o_word};
        if (held_v) chk("hold_stable", got, held);
        if (bus.i_busy) begin
          held_v = 1'b1;
          held   = got;
        end else begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", got);
          end else begin
            e = exp_q.pop_front();
            chk("beat", got, e);
          end
          got_q.push_back(got);
        end
      end
    end
  end

  task automatic send(input logic [34:0] w);
    int n;
    n = 0;
    bus.i_stb  = 1'b1;
    bus.i_word = w;
    @(negedge clk);
    while (bus.o_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (bus.o_busy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=busy required=accept word=%h", w);
    end else begin
      @(posedge clk);
      model_push(w);
      #1;
    end
    bus.i_stb = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_busy = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.o_stb || o_active) && n < 500);
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [34:0] vec_w [10];
  logic [35:0] vec_e [10];

  initial begin : main
    vec_w = '{ {2'b00, 1'b0, 32'h12345679},
               {2'b00, 2'b10, 2'b11, 29'h0},
               {2'b00, 3'b110, 1'b0, 7'h40, 22'h0},
               {2'b00, 3'b111, 1'b1, 14'h1FFF, 15'h0},
               rds(4'hF), spc(5'b00101), wr15(15'h4000),
               lks(2'd0), lks(2'd1), lks(2'd2) };
    vec_e = '{ {1'b0, 3'b000, 32'h12345679},
               {1'b0, 3'b001, 32'hFFFFFFFF},
               {1'b0, 3'b000, 32'hFFFFFFC0},
               {1'b0, 3'b001, 32'h00001FFF},
               {1'b0, 2'b10, 21'h0, 12'd16},
               {1'b0, 2'b11, 5'b00101, 28'h0},
               {1'b0, 3'b010, 32'hFFFFC000},
               {1'b0, 3'b010, 32'hFFFFC000},
               {1'b0, 3'b010, 32'hDEADBEEF},
               {1'b1, 3'b010, 32'h0} };

    bus.i_stb = 1'b0; bus.i_word = '0; bus.i_busy = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_stb",    {35'h0, bus.o_stb},  36'h0);
    chk("rst_o_err",    {35'h0, bus.o_err},  36'h0);
    chk("rst_o_word",   {1'b0, bus.o_word},  36'h0);
    chk("rst_o_busy",   {35'h0, bus.o_busy}, 36'h0);
    chk("rst_o_active", {35'h0, o_active},   36'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write then immediate offset-0 lookup (bypass path)
    got_q.delete();
    send(wr(32'hDEADBEEF));
    send(lks(2'd0));
    drain();
    chk("t1_write",  got_q[0], {1'b0, 3'b010, 32'hDEADBEEF});
    chk("t1_lookup", got_q[1], {1'b0, 3'b010, 32'hDEADBEEF});

    // Unstored 8-bit write does not shadow the history
    got_q.delete();
    send(wr8(8'h80));
    send(lks(2'd0));
    drain();
    chk("t2_wr8",    got_q[0], {1'b0, 3'b010, 32'hFFFFFF80});
    chk("t2_lookup", got_q[1], {1'b0, 3'b010, 32'hDEADBEEF});

    // Decode table under random downstream stalls
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) send(vec_w[i]);
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          bus.i_busy = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    for (int i = 0; i < 10; i++) chk($sformatf("t3_vec%0d", i), got_q[i], vec_e[i]);

    // Long read count with output held busy for 10 cycles
    got_q.delete();
    bus.i_busy = 1'b1;
    fork
      begin
        send(rdl(11'h7FF));
        send(wr(32'hA5A5A5A5));
        send(rds(4'h0));
        send(lks(2'd0));
        send(wr8(8'h7F));
      end
      begin
        repeat (9) @(posedge clk);
        #1;
        chk("t4_stall_busy", {35'h0, bus.o_busy}, 36'h1);
        chk("t4_stall_stb",  {35'h0, bus.o_stb},  36'h1);
        @(posedge clk);
        #1;
        bus.i_busy = 1'b0;
      end
    join
    drain();
    chk("t4_read_long", got_q[0], {1'b0, 2'b10, 21'h0, 12'd2064});
    chk("t4_read_one",  got_q[2], {1'b0, 2'b10, 21'h0, 12'd1});
    chk("t4_lookup",    got_q[3], {1'b0, 3'b010, 32'hA5A5A5A5});
    chk("t4_count",     36'(got_q.size()), 36'd5);

    // Flush is consumed and invalidates all history
    got_q.delete();
    send(wr(32'd1)); send(wr(32'd2)); send(wr(32'd3));
    send(spc(5'b11110));
    send(lks(2'd0));
    drain();
    chk("t5_count",  36'(got_q.size()), 36'd4);
    chk("t5_stale",  got_q[3], {1'b1, 3'b010, 32'h0});

    // Long offset reach and pointer wrap
    got_q.delete();
    for (int i = 1; i <= 600; i++) send(wr(32'(i)));
    send(lkl(9'd511));
    drain();
    chk("t6_off511", got_q[600], {1'b0, 3'b010, 32'd89});
    got_q.delete();
    for (int i = 601; i <= 1030; i++) send(wr(32'(i)));
    send(lks(2'd0));
    send(lkl(9'd10));
    drain();
    chk("t6_wrap_off0",  got_q[430], {1'b0, 3'b010, 32'd1030});
    chk("t6_wrap_off10", got_q[431], {1'b0, 3'b010, 32'd1020});

    // Reset in the middle of a stalled burst
    bus.i_busy = 1'b1;
    send(wr(32'd77));
    send(wr(32'd78));
    send(lks(2'd0));
    rst = 1'b1;
    exp_q.delete();
    hist_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_busy = 1'b0;
    @(negedge clk);
    chk("t7_o_stb",    {35'h0, bus.o_stb}, 36'h0);
    chk("t7_o_active", {35'h0, o_active},  36'h0);
    @(posedge clk);
    #1;
    got_q.delete();
    send(lks(2'd0));
    drain();
    chk("t7_stale", got_q[0], {1'b1, 3'b010, 32'h0});
    chk("end_pending", 36'(exp_q.size()), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
